// File: rtl/mem_write_checker_pkg.sv
// Shared types for the data-memory write checker: FSM states and verdict code.
package mem_write_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_PASS = 3'd2,
        ST_FAIL = 3'd3,
        ST_TOUT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        VERDICT_NONE = 2'd0,
        VERDICT_PASS = 2'd1,
        VERDICT_FAIL = 2'd2,
        VERDICT_TOUT = 2'd3
    } verdict_t;

    // Maps the checker state onto the externally visible verdict.
    function automatic verdict_t verdict_of(state_t s);
        verdict_t v;
        v = VERDICT_NONE;
        case (s)
            ST_PASS: v = VERDICT_PASS;
            ST_FAIL: v = VERDICT_FAIL;
            ST_TOUT: v = VERDICT_TOUT;
            default: v = VERDICT_NONE;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/mem_write_checker_if.sv
// Expected-entry load channel and monitored CPU store port, bundled for the checker.
interface mem_write_checker_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              exp_valid;
    logic              exp_ready;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic              memwrite;
    logic [ADDR_W-1:0] dataadr;
    logic [DATA_W-1:0] writedata;

    // Driven by the table loader and the CPU under test.
    modport master (
        output exp_valid, exp_addr, exp_data, memwrite, dataadr, writedata,
        input  exp_ready
    );

    // Seen by the checker.
    modport slave (
        input  exp_valid, exp_addr, exp_data, memwrite, dataadr, writedata,
        output exp_ready
    );
endinterface

// File: rtl/mem_write_checker_sync_fifo.sv
// Small synchronous FIFO holding the expected (addr,data) stores; head is read
// combinationally so a store can be compared in the cycle it appears.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr_reg];
    assign count   = count_reg;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/mem_write_checker.sv
// Data-memory write checker: compares CPU stores in order against a loaded table,
// skips the scratch address, and guards the run with an idle-cycle watchdog.
module mem_write_checker
    import mem_write_checker_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 8,
    parameter int SCRATCH_ADDR = 80,
    parameter int TIMEOUT      = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_write_checker_if.slave     bus,
    input  logic                   start,
    output logic                   done,
    output logic                   pass,
    output logic                   fail,
    output logic                   timeout,
    output logic [$clog2(DEPTH):0] err_index,
    output logic [ADDR_W-1:0]      err_addr,
    output logic [DATA_W-1:0]      err_data,
    output logic [$clog2(DEPTH):0] match_cnt
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    // Watchdog only ever needs to reach TIMEOUT-1; with TIMEOUT=0 it just saturates.
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t             state_reg, state_next;
    logic [WD_W-1:0]    wd_reg, wd_next;
    logic [CNT_W-1:0]   match_cnt_reg, match_cnt_next;
    logic [CNT_W-1:0]   err_index_reg, err_index_next;
    logic [ADDR_W-1:0]  err_addr_reg, err_addr_next;
    logic [DATA_W-1:0]  err_data_reg, err_data_next;

    logic [ADDR_W+DATA_W-1:0] head;
    logic [ADDR_W-1:0]        head_addr;
    logic [DATA_W-1:0]        head_data;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CNT_W-1:0]         fifo_count;
    logic                     load_ok;
    logic                     pop;
    logic                     is_scratch;
    logic                     head_hit;
    verdict_t                 verdict;

    assign bus.exp_ready = (state_reg == ST_IDLE) && !fifo_full;
    assign load_ok       = bus.exp_valid && bus.exp_ready;
    assign head_addr     = head[ADDR_W+DATA_W-1:DATA_W];
    assign head_data     = head[DATA_W-1:0];
    assign is_scratch    = (bus.dataadr == ADDR_W'(SCRATCH_ADDR));
    assign head_hit      = (bus.dataadr == head_addr) && (bus.writedata == head_data);

    sync_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (load_ok),
        .push_data ({bus.exp_addr, bus.exp_data}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Next-state logic: load/start in IDLE, store comparison and watchdog in RUN.
    // An X/Z on the bus makes the equality tests unknown, which falls through to FAIL.
    always_comb begin
        state_next     = state_reg;
        wd_next        = wd_reg;
        match_cnt_next = match_cnt_reg;
        err_index_next = err_index_reg;
        err_addr_next  = err_addr_reg;
        err_data_next  = err_data_reg;
        pop            = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                wd_next = '0;
                if (start) begin
                    if (!fifo_empty || load_ok) begin
                        state_next = ST_RUN;
                    end else begin
                        state_next     = ST_FAIL;
                        err_index_next = '0;
                        err_addr_next  = '0;
                        err_data_next  = '0;
                    end
                end
            end
            ST_RUN: begin
                if (bus.memwrite) begin
                    if (is_scratch) begin
                        wd_next = '0;
                    end else if (head_hit) begin
                        pop            = 1'b1;
                        match_cnt_next = match_cnt_reg + CNT_W'(1);
                        wd_next        = '0;
                        if (fifo_count == CNT_W'(1)) begin
                            state_next = ST_PASS;
                        end
                    end else begin
                        state_next     = ST_FAIL;
                        err_index_next = match_cnt_reg;
                        err_addr_next  = bus.dataadr;
                        err_data_next  = bus.writedata;
                    end
                end else if ((TIMEOUT != 0) && (wd_reg == WD_LAST)) begin
                    state_next = ST_TOUT;
                end else if (wd_reg != '1) begin
                    wd_next = wd_reg + WD_W'(1);
                end
            end
            ST_PASS, ST_FAIL, ST_TOUT: begin
                state_next = state_reg;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, watchdog, match counter and error capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            wd_reg        <= '0;
            match_cnt_reg <= '0;
            err_index_reg <= '0;
            err_addr_reg  <= '0;
            err_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            wd_reg        <= wd_next;
            match_cnt_reg <= match_cnt_next;
            err_index_reg <= err_index_next;
            err_addr_reg  <= err_addr_next;
            err_data_reg  <= err_data_next;
        end
    end

    assign verdict   = verdict_of(state_reg);
    assign pass      = (verdict == VERDICT_PASS);
    assign fail      = (verdict == VERDICT_FAIL);
    assign timeout   = (verdict == VERDICT_TOUT);
    assign done      = (verdict != VERDICT_NONE);
    assign err_index = err_index_reg;
    assign err_addr  = err_addr_reg;
    assign err_data  = err_data_reg;
    assign match_cnt = match_cnt_reg;
endmodule
